blink_mode_controller: RTL
==========================

Name: blink_mode_controller

Overview:
- Sequences the LED blink datapath: one 26-bit period counter plus an LED toggle register, replacing the fixed 25_000_000 compare with a per-mode terminal count.
- A debounced push-button steps through OFF -> SLOW -> MED -> FAST -> ON -> OFF.
- Sits between the debouncer output and the board LED.
- Exports the current mode and a toggle tick so other logic can follow the blink phase.

Parameters:
- CLK_HZ, 50_000_000, input clock frequency in Hz.
- SLOW_HZ, 1, blink rate in SLOW mode (full LED periods per second).
- MED_HZ, 4, blink rate in MED mode.
- FAST_HZ, 16, blink rate in FAST mode.
- LONG_PRESS_CYC, 50_000_000, hold length in cycles for the long-press return to OFF. Used only with LONG_PRESS_EN.

Ports:
- CLK50M  input  1  system clock, 50 MHz.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- key_clean  input  1  debounced button level; active-low (0 = pressed); asynchronous to CLK50M.
- LED0  output  1  LED drive, registered.
- mode  output  3  current mode: 0 OFF, 1 SLOW, 2 MED, 3 FAST, 4 ON.
- period_tick  output  1  one-cycle pulse on every LED toggle in blink modes.

Behaviour:
- Reset (reset=0, asynchronous, takes effect immediately, including mid-blink or mid-hold):
  - mode=OFF, LED0=0, period_tick=0.
  - Period counter=0.
  - Key synchroniser flops=1 (released).
  - Hold counter=0.
- Key path:
  - key_clean goes through a 2-FF synchroniser, then a previous-value flop.
  - A press is a 1->0 transition at the synchroniser output.
  - key_clean first sampled low at edge N gives a mode update at edge N+3.
  - A held key produces exactly one press. Release (0->1) has no effect.
- Mode FSM:
  - Advances one step per press: OFF->SLOW->MED->FAST->ON->OFF (ON wraps to OFF).
  - mode is a register with no other transitions, except the long press (optional feature).
- Half-period constants:
  - HALF_x = CLK_HZ/(2*x_HZ) for SLOW, MED and FAST; integer division.
  - All are localparams of 26 bits.
  - Elaboration check: every HALF_x is in 1..2^26.
- Mode entry, on the same edge as the mode update:
  - Period counter is cleared to 0.
  - LED0 = 1 when entering ON, otherwise 0.
  - period_tick = 0.
- Blink modes (SLOW, MED, FAST):
  - Counter increments each cycle, 0..HALF-1.
  - On the edge where counter==HALF-1: counter becomes 0, LED0 inverts, period_tick=1 for that one cycle.
  - First toggle comes HALF cycles after mode entry. LED period = 2*HALF cycles, 50% duty.
- OFF and ON modes: counter held at 0, LED0 constant (0 in OFF, 1 in ON), period_tick=0.
- Simultaneous press and terminal count: the press wins. Mode entry rules apply, with no toggle and no tick that cycle.
- Counter never exceeds HALF-1 and never wraps past 2^26.

Optional Feature:
- Macro: LONG_PRESS_EN.
- Defined:
  - A 26-bit hold counter increments while the synchronised key is 0 and saturates at LONG_PRESS_CYC-1.
  - It clears to 0 whenever the key is 1.
  - On the cycle it reaches LONG_PRESS_CYC-1, if mode != OFF, mode goes to OFF with OFF entry rules. This fires once per hold.
  - The initial press still advances the mode first. Example: SLOW, press and hold gives MED, then OFF after LONG_PRESS_CYC cycles.
- Undefined: no hold counter is built, holding the key has no effect, and LONG_PRESS_CYC is ignored.

Decomposition:
- Package blink_ctrl_pkg holds:
  - typedef enum logic [2:0] mode_t {MODE_OFF=0, MODE_SLOW=1, MODE_MED=2, MODE_FAST=3, MODE_ON=4}.
  - localparam CNT_W=26.
- Sub-module key_edge_sync contains the 2-FF synchroniser, the previous-value flop, and the falling-edge press pulse. Its outputs are press and key_sync.
- The FSM, period counter and LED register stay in the top module.

Test Plan (sim parameters CLK_HZ=40, SLOW_HZ=1, MED_HZ=2, FAST_HZ=4, LONG_PRESS_CYC=30; HALF = 20/10/5):
- Reset: hold reset=0 mid-FAST, then release -> LED0=0, mode=0 and period_tick=0 immediately; no ticks while in OFF.
- Single press: key_clean low at edge N -> mode=1 at edge N+3; first LED0 rise and tick 20 cycles later; then ticks every 20 cycles.
- Step sequence: five separate presses -> mode goes 1,2,3,4,0; tick spacing is 10 in MED and 5 in FAST; LED0=1 steady in ON and 0 in OFF.
- Hold: key held low for 100 cycles from OFF -> mode=1 only. Without LONG_PRESS_EN it stays 1. With LONG_PRESS_EN it returns to 0 exactly 30 cycles after the hold counter starts, with no second change.
- Collision: press timed so the mode update lands on the counter==19 edge in SLOW -> mode=2, LED0=0, no tick, counter=0.
- Async reset mid-hold under LONG_PRESS_EN -> hold counter cleared; after release, a fresh 30-cycle hold is needed.

Source files
------------

// File: rtl/blink_ctrl_pkg.sv
// Shared types and constants for the LED blink mode controller.
//   mode_t         : operating mode, encoded as it appears on the mode port.
//   CNT_W          : width of the period counter (and of the hold counter).
//   next_mode_step : mode reached from a given mode by one button press.
package blink_ctrl_pkg;

    localparam int CNT_W = 26;

    typedef enum logic [2:0] {
        MODE_OFF  = 3'd0,
        MODE_SLOW = 3'd1,
        MODE_MED  = 3'd2,
        MODE_FAST = 3'd3,
        MODE_ON   = 3'd4
    } mode_t;

    function automatic mode_t next_mode_step(input mode_t cur);
        mode_t nxt;
        case (cur)
            MODE_OFF:  nxt = MODE_SLOW;
            MODE_SLOW: nxt = MODE_MED;
            MODE_MED:  nxt = MODE_FAST;
            MODE_FAST: nxt = MODE_ON;
            default:   nxt = MODE_OFF;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/key_edge_sync.sv
// Synchronises the debounced, active-low button level into the clock domain
// and turns each press (1->0 at the synchroniser output) into one pulse.
// Ports:
//   clk       : system clock
//   reset     : asynchronous active-low reset; flops reset to "released"
//   key_clean : debounced button level, 0 = pressed, asynchronous to clk
//   press     : registered one-cycle pulse per press
//   key_sync  : synchronised button level (0 = pressed)
module key_edge_sync
    import blink_ctrl_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic key_clean,
    output logic press,
    output logic key_sync
);

    logic key_p0;
    logic key_p1;
    logic key_p2;

    // Stage 0/1: two-flop synchroniser; stage 2: previous synchronised value.
    // The press pulse is registered, so a low sampled at edge N reaches the
    // mode register at edge N+3.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_p0 <= 1'b1;
            key_p1 <= 1'b1;
            key_p2 <= 1'b1;
            press  <= 1'b0;
        end else begin
            key_p0 <= key_clean;
            key_p1 <= key_p0;
            key_p2 <= key_p1;
            press  <= key_p2 & ~key_p1;
        end
    end

    assign key_sync = key_p1;

endmodule

// File: rtl/blink_mode_controller.sv
// LED blink mode controller. A debounced push-button steps the mode
// OFF -> SLOW -> MED -> FAST -> ON -> OFF; in the blink modes a period
// counter toggles the LED every half period of the selected rate.
// Optional feature macro: LONG_PRESS_EN (holding the key for LONG_PRESS_CYC
// cycles returns the controller to OFF).
// Ports:
//   CLK50M      : system clock
//   reset       : asynchronous active-low reset
//   key_clean   : debounced button level, 0 = pressed, asynchronous
//   LED0        : registered LED drive
//   mode        : current mode (0 OFF, 1 SLOW, 2 MED, 3 FAST, 4 ON)
//   period_tick : one-cycle pulse on every LED toggle in blink modes
module blink_mode_controller
    import blink_ctrl_pkg::*;
#(
    parameter int CLK_HZ         = 50_000_000,
    parameter int SLOW_HZ        = 1,
    parameter int MED_HZ         = 4,
    parameter int FAST_HZ        = 16,
    parameter int LONG_PRESS_CYC = 50_000_000
) (
    input  logic       CLK50M,
    input  logic       reset,
    input  logic       key_clean,
    output logic       LED0,
    output logic [2:0] mode,
    output logic       period_tick
);

    localparam int HALF_SLOW = CLK_HZ / (2 * SLOW_HZ);
    localparam int HALF_MED  = CLK_HZ / (2 * MED_HZ);
    localparam int HALF_FAST = CLK_HZ / (2 * FAST_HZ);
    localparam int HALF_MAX  = 1 << CNT_W;

    // Terminal counts are HALF-1 so that a half period of exactly 2^26
    // still fits the 26-bit counter.
    localparam logic [CNT_W-1:0] TERM_SLOW = CNT_W'(HALF_SLOW - 1);
    localparam logic [CNT_W-1:0] TERM_MED  = CNT_W'(HALF_MED - 1);
    localparam logic [CNT_W-1:0] TERM_FAST = CNT_W'(HALF_FAST - 1);

    if (HALF_SLOW < 1 || HALF_SLOW > HALF_MAX ||
        HALF_MED  < 1 || HALF_MED  > HALF_MAX ||
        HALF_FAST < 1 || HALF_FAST > HALF_MAX) begin : g_bad_half
        $error("blink_mode_controller: half period out of range 1..2^26");
    end

    mode_t            mode_q;
    mode_t            mode_nxt;
    logic             press;
    logic             key_sync;
    logic             long_fire;
    logic             entry;
    logic             blink;
    logic [CNT_W-1:0] term;
    logic [CNT_W-1:0] cnt;

    key_edge_sync u_key (
        .clk       (CLK50M),
        .reset     (reset),
        .key_clean (key_clean),
        .press     (press),
        .key_sync  (key_sync)
    );

`ifdef LONG_PRESS_EN
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_PRESS_CYC - 1);

    if (LONG_PRESS_CYC < 1 || LONG_PRESS_CYC > HALF_MAX) begin : g_bad_hold
        $error("blink_mode_controller: LONG_PRESS_CYC out of range 1..2^26");
    end

    logic [CNT_W-1:0] hold_cnt;
    logic             hold_done;

    // hold_done makes the long press fire once per hold even though the
    // counter stays saturated at HOLD_LAST while the key remains down.
    always_ff @(posedge CLK50M or negedge reset) begin
        if (!reset) begin
            hold_cnt  <= '0;
            hold_done <= 1'b0;
        end else if (key_sync) begin
            hold_cnt  <= '0;
            hold_done <= 1'b0;
        end else begin
            if (hold_cnt != HOLD_LAST) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
            if (hold_cnt == HOLD_LAST) begin
                hold_done <= 1'b1;
            end
        end
    end

    assign long_fire = ~key_sync & (hold_cnt == HOLD_LAST) & ~hold_done;
`else
    // Without the long-press feature the hold length and the synchronised
    // level are not needed.
    localparam int LONG_PRESS_UNUSED = LONG_PRESS_CYC;
    logic key_sync_unused;
    assign key_sync_unused = key_sync;
    assign long_fire       = 1'b0;
`endif

    always_ff @(posedge CLK50M or negedge reset) begin
        if (!reset) begin
            mode_q <= MODE_OFF;
        end else begin
            mode_q <= mode_nxt;
        end
    end

    // A press has priority over the long-press return.
    always_comb begin
        mode_nxt = mode_q;
        entry    = 1'b0;
        if (press) begin
            mode_nxt = next_mode_step(mode_q);
            entry    = 1'b1;
        end else if (long_fire && (mode_q != MODE_OFF)) begin
            mode_nxt = MODE_OFF;
            entry    = 1'b1;
        end
    end

    always_comb begin
        term  = TERM_SLOW;
        blink = 1'b0;
        case (mode_q)
            MODE_SLOW: begin term = TERM_SLOW; blink = 1'b1; end
            MODE_MED:  begin term = TERM_MED;  blink = 1'b1; end
            MODE_FAST: begin term = TERM_FAST; blink = 1'b1; end
            default:   begin term = TERM_SLOW; blink = 1'b0; end
        endcase
    end

    // Mode entry overrides the terminal count, so a press landing on the
    // toggle edge restarts the period without toggling or ticking.
    always_ff @(posedge CLK50M or negedge reset) begin
        if (!reset) begin
            cnt         <= '0;
            LED0        <= 1'b0;
            period_tick <= 1'b0;
        end else if (entry) begin
            cnt         <= '0;
            LED0        <= (mode_nxt == MODE_ON);
            period_tick <= 1'b0;
        end else if (blink) begin
            if (cnt == term) begin
                cnt         <= '0;
                LED0        <= ~LED0;
                period_tick <= 1'b1;
            end else begin
                cnt         <= cnt + 1'b1;
                period_tick <= 1'b0;
            end
        end else begin
            cnt         <= '0;
            LED0        <= (mode_q == MODE_ON);
            period_tick <= 1'b0;
        end
    end

    assign mode = mode_q;

endmodule
